// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory transfer path: controller state encoding
// and default geometry used by both the write-side and the B readback controllers.
package mem_xfer_pkg;

  localparam int DEF_WORDS  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    CSUM = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_b_out_stage.sv
// Output register for the readback stream: holds the presented word, its valid
// flag and its last-beat flag until the consumer accepts it.
module mem_b_out_stage
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  input  logic              accept,
  output logic [DATA_W-1:0] q_data,
  output logic              q_valid,
  output logic              q_last
);

  // A load wins over an accept on the same edge, so a new beat can follow an
  // accepted one back to back; the word itself is kept after acceptance.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end else if (load) begin
      q_data  <= data;
      q_valid <= 1'b1;
      q_last  <= last;
    end else if (accept) begin
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_b_reader.sv
// Drains memory B from address 0 upward onto a valid/ready stream.
// Optional trailing XOR checksum beat when READBACK_CSUM_EN is defined.
module mem_b_reader
  import mem_xfer_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Start,
  output logic              REB,
  output logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataB,
  output logic [DATA_W-1:0] DOut,
  output logic              DValid,
  input  logic              DReady,
  output logic              DLast,
  output logic              Busy,
  output logic              Done,
  output state_t            fsm_state
);

  // Stream handshake: a beat transfers on a rising edge where DValid && DReady;
  // while DValid is high and DReady low, DOut and DLast do not change.

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              last_idx;
  logic              stage_load;
  logic              stage_last;
  logic [DATA_W-1:0] stage_data;

`ifdef READBACK_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  assign accept    = DValid && DReady;
  assign last_idx  = (idx == LAST_IDX);
  assign fsm_state = state;

  always_comb begin
    stage_load = 1'b0;
    stage_last = 1'b0;
    stage_data = DataB;
    if (state == LOAD) begin
      stage_load = 1'b1;
`ifndef READBACK_CSUM_EN
      stage_last = last_idx;
`endif
    end
`ifdef READBACK_CSUM_EN
    // The checksum beat is loaded on the edge that accepts the last data word.
    if (state == SEND && accept && last_idx) begin
      stage_load = 1'b1;
      stage_last = 1'b1;
      stage_data = csum;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      state <= IDLE;
      idx   <= '0;
      REB   <= 1'b0;
      AddrB <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
`ifdef READBACK_CSUM_EN
      csum  <= '0;
`endif
    end else begin
      REB  <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= READ;
            idx   <= '0;
            REB   <= 1'b1;
            AddrB <= '0;
            Busy  <= 1'b1;
`ifdef READBACK_CSUM_EN
            csum  <= '0;
`endif
          end
        end
        READ: state <= LOAD;
        LOAD: begin
          state <= SEND;
`ifdef READBACK_CSUM_EN
          csum  <= csum ^ DataB;
`endif
        end
        SEND: begin
          if (accept) begin
            if (last_idx) begin
`ifdef READBACK_CSUM_EN
              state <= CSUM;
`else
              state <= FIN;
              Done  <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
              REB   <= 1'b1;
              AddrB <= idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            state <= FIN;
            Done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_b_out_stage #(
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clock  (clock),
    .Reset  (Reset),
    .load   (stage_load),
    .last   (stage_last),
    .data   (stage_data),
    .accept (accept),
    .q_data (DOut),
    .q_valid(DValid),
    .q_last (DLast)
  );

endmodule

// File: tb/tb_mem_b_reader.sv
// Bench for mem_b_reader: a behavioural memory B plus an expected-beat queue
// built from B's contents; run length is predicted from word count and stalls.
module tb_mem_b_reader;
  import mem_xfer_pkg::*;

  localparam int WORDS  = DEF_WORDS;
  localparam int DATA_W = DEF_DATA_W;
  localparam int ADDR_W = DEF_ADDR_W;

  logic              clock = 1'b0;
  logic              Reset;
  logic              Start;
  logic              REB;
  logic [ADDR_W-1:0] AddrB;
  logic [DATA_W-1:0] DataB = '0;
  logic [DATA_W-1:0] DOut;
  logic              DValid;
  logic              DReady;
  logic              DLast;
  logic              Busy;
  logic              Done;
  state_t            fsm_state;

  logic [DATA_W-1:0] mem_b [2**ADDR_W];
  logic [DATA_W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clock = ~clock;

  // memory B: synchronous read, data valid the cycle after REB
  always @(posedge clock) if (REB) DataB <= mem_b[AddrB];

  mem_b_reader dut (
    .clock    (clock),
    .Reset    (Reset),
    .Start    (Start),
    .REB      (REB),
    .AddrB    (AddrB),
    .DataB    (DataB),
    .DOut     (DOut),
    .DValid   (DValid),
    .DReady   (DReady),
    .DLast    (DLast),
    .Busy     (Busy),
    .Done     (Done),
    .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_fixed();
    mem_b[0] = 8'h11; mem_b[1] = 8'h22; mem_b[2] = 8'h33; mem_b[3] = 8'h44;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2**ADDR_W; i++) mem_b[i] = DATA_W'($urandom_range(0, 255));
  endtask

  // One run from IDLE to Done; stall_at is the beat index held off stall_len cycles.
  task automatic drive_run(input bit hold_start, input bit rand_ready,
                           input int stall_at, input int stall_len);
    logic [DATA_W-1:0] x;
    int rel, stalls, beat, reb_cnt, stall_left, exp_len;
    bit rdy, prev_stall, done_seen, first_valid, stall_used;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < WORDS; i++) begin
      exp_q.push_back(mem_b[i]);
      x ^= mem_b[i];
    end
`ifdef READBACK_CSUM_EN
    exp_q.push_back(x);
    exp_len = 3 * WORDS + 2;
`else
    exp_len = 3 * WORDS + 1;
`endif
    rel = 0; stalls = 0; beat = 0; reb_cnt = 0; stall_left = 0;
    prev_stall = 0; done_seen = 0; first_valid = 0; stall_used = 0;
    @(negedge clock);
    Start = 1'b1;
    while (!done_seen && rel < 400) begin
      @(negedge clock);
      rel++;
      if (!hold_start) Start = 1'b0;
      if (rel == 1) begin
        check("reb_first", 32'(REB), 1);
        check("addr_first", 32'(AddrB), 0);
      end
      check("busy_run", 32'(Busy), 1);
      if (REB) begin
        check("addr_seq", 32'(AddrB), 32'(reb_cnt));
        reb_cnt++;
      end
      if (prev_stall) check("hold_valid", 32'(DValid), 1);
      if (DValid && !stall_used && beat == stall_at) begin
        stall_left = stall_len;
        stall_used = 1;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (DValid) begin
        if (!first_valid) begin
          check("first_valid_cycle", 32'(rel), 3);
          first_valid = 1;
        end
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("dout", 32'(DOut), 32'(exp_q[0]));
          check("dlast", 32'(DLast), 32'(exp_q.size() == 1));
          if (rdy) begin
            void'(exp_q.pop_front());
            beat++;
          end
        end
        if (!rdy) stalls++;
      end
      prev_stall = DValid && !rdy;
      DReady = rdy;
      if (Done) begin
        done_seen = 1;
        check("done_cycle", 32'(rel), 32'(exp_len + stalls));
        check("beats_left", 32'(exp_q.size()), 0);
        check("reads", 32'(reb_cnt), 32'(WORDS));
      end
    end
    if (!done_seen) check("done_timeout", 0, 1);
  endtask

  task automatic after_run();
    @(negedge clock);
    check("done_pulse", 32'(Done), 0);
    check("busy_idle", 32'(Busy), 0);
    check("valid_idle", 32'(DValid), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reb"}, 32'(REB), 0);
    check({tag, "_addr"}, 32'(AddrB), 0);
    check({tag, "_dout"}, 32'(DOut), 0);
    check({tag, "_dvalid"}, 32'(DValid), 0);
    check({tag, "_dlast"}, 32'(DLast), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_done"}, 32'(Done), 0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  task automatic reset_mid_send();
    int beats;
    bit hit;
    fill_fixed();
    beats = 0;
    hit = 0;
    DReady = 1'b1;
    @(negedge clock);
    Start = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clock);
      Start = 1'b0;
      if (DValid) begin
        if (beats == 2) begin
          check("pre_reset_word", 32'(DOut), 32'(mem_b[2]));
          Reset = 1'b0;
          DReady = 1'b0;
          hit = 1;
        end else begin
          beats++;
        end
      end
    end
    if (!hit) check("reset_target_timeout", 0, 1);
    @(negedge clock);
    check_reset_values("mid_reset");
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    DReady = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) mem_b[i] = '0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    Reset = 1'b1;

    fill_fixed();
    drive_run(0, 0, -1, 0);
    after_run();

    drive_run(0, 0, 1, 5);
    after_run();

    reset_mid_send();
    repeat (2) @(negedge clock);
    check("no_done_after_reset", 32'(Done), 0);
    drive_run(0, 0, -1, 0);
    after_run();

    // Start held through the whole run: one run, restart only from IDLE.
    drive_run(1, 0, -1, 0);
    @(negedge clock);
    check("held_idle_reb", 32'(REB), 0);
    check("held_idle_busy", 32'(Busy), 0);
    @(negedge clock);
    check("held_restart_reb", 32'(REB), 1);
    check("held_restart_addr", 32'(AddrB), 0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;

    for (int r = 0; r < 6; r++) begin
      fill_random();
      drive_run(0, 1, (r % 2 == 0) ? int'($urandom_range(0, WORDS - 1)) : -1,
                int'($urandom_range(1, 4)));
      after_run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_b_reader.md
# mem_b_reader

Readback controller for the memory transfer path: once memory B has been filled by the transfer controller, this block walks B's addresses from 0 upward. It issues synchronous reads and presents each word on a valid/ready output stream. It sits on B's read port, opposite the write-side controller, and drains B to a downstream consumer with full backpressure support.

## Interface
- WORDS, default 4: number of words read from B per run (≥1)
- DATA_W, default 8: word width
- ADDR_W, default 2: B address width; WORDS ≤ 2**ADDR_W

- clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- Start  in  1  begin a readback run; sampled only in IDLE
- REB  out  1  read enable to memory B
- AddrB  out  ADDR_W  read address to memory B
- DataB  in  DATA_W  B read data, valid the cycle after REB
- DOut  out  DATA_W  output word
- DValid  out  1  DOut holds a valid word
- DReady  in  1  consumer accepts word when DValid&&DReady at clock edge
- DLast  out  1  qualifies final beat of the run (with DValid)
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, READ, LOAD, SEND, FIN.
- IDLE: Start=1 → READ; word index idx cleared to 0.
- READ: REB=1, AddrB=idx → LOAD (one cycle).
- LOAD: DataB captured into DOut at end of cycle → SEND.
- SEND: DValid=1; DOut, DLast stable while DReady=0. On DValid&&DReady: if idx==WORDS-1 (last data beat) → FIN (or CSUM, see Configuration); else idx+1 → READ.
- FIN: Done=1 for exactly one cycle → IDLE.
- REB=0 and AddrB holds last driven value outside READ.
- idx never wraps: it runs 0..WORDS-1 per run and resets to 0 on next Start.
- Start outside IDLE ignored; no queuing.
- Reset=0 (any state, incl. mid-SEND with beat unaccepted): next edge → IDLE; beat dropped, no Done.
- Reset values: REB=0, AddrB=0, DOut=0, DValid=0, DLast=0, Busy=0, Done=0, idx=0.

## Timing
- Start high at edge N (in IDLE) → REB=1, AddrB=0 in cycle N+1; DValid=1 from cycle N+3.
- Minimum 3 cycles per word with DReady tied high; WORDS=4 run: Start to Done pulse = 3·WORDS+1 cycles after Start edge (13).
- Each DReady-low cycle in SEND extends the run by exactly one cycle.
- Done asserted the cycle after the final accepting edge; Busy falls with Done's deassertion (IDLE).
- Start sampled high in the Done cycle is ignored; Start is accepted from the following IDLE cycle.

## Configuration
- READBACK_CSUM_EN defined: extra state CSUM after last data beat; running XOR of all WORDS words (DATA_W bits, cleared at Start) presented as one additional beat with DValid=1, DLast=1, same handshake; accept → FIN. DLast=0 on all data beats.
- Undefined: no CSUM state, no accumulator; DLast=1 on the last data beat.

## Structure
- Shared package mem_xfer_pkg: state enum (IDLE, READ, LOAD, SEND, CSUM, FIN), default WORDS/DATA_W/ADDR_W constants shared with the write-side controller.
- One sub-module natural: mem_b_out_stage — output register holding DOut/DValid/DLast with load and accept controls.

## Test plan
- B={0x11,0x22,0x33,0x44}, DReady=1, Start pulse → DOut 0x11,0x22,0x33,0x44 on DValid, AddrB 0..3, DLast on 0x44, Done 13 cycles after Start.
- Same, DReady low 5 cycles on word 0x22 → DOut held at 0x22 with DValid=1 throughout, run lengthens by 5, no duplicate/lost word.
- Reset=0 during SEND of 0x33 → next cycle all outputs at reset values, no Done; new Start restarts at AddrB=0.
- Start held high for whole run → single run only; second run begins only once Start is seen in IDLE after Done.
- READBACK_CSUM_EN, same data → fifth beat DOut=0x44 (XOR) with DLast=1; DLast=0 on data beats; Done after its acceptance.
- WORDS=1, B[0]=0xA5 → single beat 0xA5 with DLast=1, Done 4 cycles after Start.
